// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm: RC4 key-scheduling swap loop over a single-port 256x8 S memory.
// For i = 0..2**ADDR_W-1: j += S[i] + key[i mod KEY_BYTES]; swap S[i], S[j].
// Optional build macro KSA_SWAP_SAME_SKIP_EN: when the new j equals i, skip the
// read of S[j] and both writes. This is safe because swapping S[i] with itself
// is a no-op.
module ksa_swap_fsm #(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [ADDR_W-1:0]      q,
    output logic [ADDR_W-1:0]      address,
    output logic [ADDR_W-1:0]      data,
    output logic                   wren,
    output logic                   busy,
    output logic                   done
);

    localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_I  = '1;
    localparam logic [KI_W-1:0]   LAST_KI = KI_W'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_I,
        S_CAP_I,
        S_RD_J,
        S_CAP_J,
        S_WR_I,
        S_WR_J,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_j;
    logic [ADDR_W-1:0] r_si;
    logic [ADDR_W-1:0] r_sj;
    logic [KI_W-1:0]   r_key_idx;
    logic [7:0]        w_key_byte;
    logic [ADDR_W-1:0] w_j_new;

    // Select the current key byte (byte 0 is the most significant) and form the next j.
    always_comb begin
        w_key_byte = secret_key[8*(KEY_BYTES - 1 - int'(r_key_idx)) +: 8];
        w_j_new    = r_j + q + ADDR_W'(w_key_byte);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: every clocked register uses <= so all of them update together from
        // pre-edge values; a blocking = here would let later lines see new values.
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and memory-port outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one
        // unassigned; an unassigned path would infer a latch.
        w_next  = r_state;
        address = '0;
        data    = '0;
        wren    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_RD_I;
                end
            end
            S_RD_I: begin
                address = r_i;
                w_next  = S_CAP_I;
            end
            S_CAP_I: begin
`ifdef KSA_SWAP_SAME_SKIP_EN
                w_next = (w_j_new == r_i) ? S_NEXT : S_RD_J;
`else
                w_next = S_RD_J;
`endif
            end
            S_RD_J: begin
                address = r_j;
                w_next  = S_CAP_J;
            end
            S_CAP_J: begin
                w_next = S_WR_I;
            end
            S_WR_I: begin
                address = r_i;
                data    = r_sj;
                wren    = 1'b1;
                w_next  = S_WR_J;
            end
            S_WR_J: begin
                address = r_j;
                data    = r_si;
                wren    = 1'b1;
                w_next  = S_NEXT;
            end
            S_NEXT: begin
                w_next = (r_i == LAST_I) ? S_DONE : S_RD_I;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Loop datapath: indices, key position and captured S values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_i       <= '0;
            r_j       <= '0;
            r_si      <= '0;
            r_sj      <= '0;
            r_key_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i       <= '0;
                        r_j       <= '0;
                        r_key_idx <= '0;
                    end
                end
                S_CAP_I: begin
                    r_si <= q;
                    r_j  <= w_j_new;
                end
                S_CAP_J: begin
                    r_sj <= q;
                end
                S_NEXT: begin
                    // i stops at its last value; there is no second pass.
                    if (r_i != LAST_I) begin
                        r_i <= r_i + 1'b1;
                    end
                    r_key_idx <= (r_key_idx == LAST_KI) ? '0 : r_key_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb_ksa_swap_fsm: drives ksa_swap_fsm against a synchronous 256x8 RAM model.
// A software RC4 KSA walk produces the expected per-cycle port trace. A single
// compare process checks the DUT against that trace on every falling edge.
module tb_ksa_swap_fsm;

`ifdef KSA_SWAP_SAME_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        busy;
    logic        done;

    ksa_swap_fsm #(.KEY_BYTES(3), .ADDR_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port RAM: read data appears the cycle after the address.
    logic [7:0] mem [256];
    bit         init_id = 1'b0;
    always @(posedge clock) begin
        if (init_id) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else begin
            if (wren) mem[address] <= data;
            q <= mem[address];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One expected cycle: address/data are compared only where defined.
    typedef struct {
        bit         ca;
        bit         cd;
        logic [7:0] a;
        logic [7:0] d;
        logic       w;
        logic       b;
        logic       dn;
    } exp_t;

    exp_t       exp_q[$];
    int         m_total;
    int         m_same;
    int         m_done_idx;
    logic [7:0] mj [256];
    logic [7:0] wa [2];
    logic [7:0] wd [2];
    logic [7:0] snap [256];
    logic [7:0] ref_s [256];
    bit         trace_on = 1'b0;
    int         done_cyc;
    int         done_cnt;

    function automatic logic [7:0] key_byte(input logic [23:0] key, input int i);
        logic [23:0] k;
        k = key;
        return k[8*(2 - (i % 3)) +: 8];
    endfunction

    function automatic exp_t mk(input bit ca, input logic [7:0] a, input bit cd,
                                input logic [7:0] d, input logic w, input logic b,
                                input logic dn);
        exp_t e;
        e.ca = ca; e.a = a; e.cd = cd; e.d = d; e.w = w; e.b = b; e.dn = dn;
        return e;
    endfunction

    // Walk the KSA on a copy of the memory snapshot, emitting the expected cycle trace.
    task automatic build_trace(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] j, t;
        int         nw;
        s = snap;
        j = 8'd0;
        nw = 0;
        m_same = 0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(mk(1, 8'(i), 0, 8'd0, 0, 1, 0));       // read S[i]
            exp_q.push_back(mk(0, 8'd0, 0, 8'd0, 0, 1, 0));        // S[i] arrives
            j = j + s[i] + key_byte(key, i);
            mj[i] = j;
            if (j == 8'(i)) m_same++;
            if (!(SKIP && j == 8'(i))) begin
                exp_q.push_back(mk(1, j, 0, 8'd0, 0, 1, 0));       // read S[j]
                exp_q.push_back(mk(0, 8'd0, 0, 8'd0, 0, 1, 0));    // S[j] arrives
                exp_q.push_back(mk(1, 8'(i), 1, s[j], 1, 1, 0));   // S[i] <= old S[j]
                exp_q.push_back(mk(1, j, 1, s[i], 1, 1, 0));       // S[j] <= old S[i]
                if (nw < 2) begin
                    wa[nw] = 8'(i); wd[nw] = s[j];
                    wa[nw+1] = j;   wd[nw+1] = s[i];
                    nw = 2;
                end
                t = s[i]; s[i] = s[j]; s[j] = t;
            end
            exp_q.push_back(mk(0, 8'd0, 0, 8'd0, 0, 1, 0));        // advance i
        end
        exp_q.push_back(mk(0, 8'd0, 0, 8'd0, 0, 1, 1));            // completion pulse
        m_done_idx = exp_q.size();
        exp_q.push_back(mk(1, 8'd0, 1, 8'd0, 0, 0, 0));            // back to idle
        m_total = exp_q.size();
    endtask

    // Plain software RC4 KSA on the snapshot, used for the final memory image.
    task automatic sw_ksa(input logic [23:0] key);
        logic [7:0] j, t;
        ref_s = snap;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j = j + ref_s[i] + key_byte(key, i);
            t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
        end
    endtask

    // Compare process: one trace entry per cycle while a run is being traced.
    always @(negedge clock) begin
        if (trace_on && exp_q.size() > 0) begin
            exp_t e;
            int   idx;
            e   = exp_q.pop_front();
            idx = m_total - exp_q.size();
            if (idx == 1) begin
                done_cyc = 0;
                done_cnt = 0;
            end
            check($sformatf("c%0d wren", idx), 32'(wren), 32'(e.w));
            check($sformatf("c%0d busy", idx), 32'(busy), 32'(e.b));
            check($sformatf("c%0d done", idx), 32'(done), 32'(e.dn));
            if (e.ca) check($sformatf("c%0d address", idx), 32'(address), 32'(e.a));
            if (e.cd) check($sformatf("c%0d data", idx), 32'(data), 32'(e.d));
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = idx;
            end
        end
    end

    task automatic init_identity();
        @(negedge clock);
        init_id = 1'b1;
        @(posedge clock);
        #1 init_id = 1'b0;
    endtask

    task automatic launch(input logic [23:0] key);
        snap = mem;
        secret_key = key;
        build_trace(key);
        sw_ksa(key);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        trace_on = 1'b1;
    endtask

    task automatic finish_run(input string name);
        for (int k = 0; k < 4000 && exp_q.size() > 0; k++) @(negedge clock);
        check({name, " timeout"}, 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        trace_on = 1'b0;
        exp_q.delete();
        check({name, " done count"}, 32'(done_cnt), 32'd1);
        check({name, " done cycle"}, 32'(done_cyc), 32'(1793 - (SKIP ? 4 * m_same : 0)));
        for (int k = 0; k < 256; k++)
            check($sformatf("%s S[%0d]", name, k), 32'(mem[k]), 32'(ref_s[k]));
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        secret_key = 24'd0;
        #1 check("reset outputs", {address, data, wren, busy, done}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check($sformatf("idle c%0d outputs", c), {address, data, wren, busy, done}, 32'd0);
        end

        // Key 0x010203 from identity: j=1 at i=0, writes (0,1),(1,0), then j=3 at i=1.
        init_identity();
        launch(24'h010203);
        check("model j0", 32'(mj[0]), 32'd1);
        check("model j1", 32'(mj[1]), 32'd3);
        check("model wr0", {wa[0], wd[0]}, 32'h0001);
        check("model wr1", {wa[1], wd[1]}, 32'h0100);
        finish_run("k010203");

        // All-zero key from identity: completion lands at cycle 1793 on the full path.
        init_identity();
        launch(24'h000000);
        check("model done idx k0", 32'(m_done_idx), 32'(1793 - (SKIP ? 4 * m_same : 0)));
        finish_run("k000000");

        // Key 0x00033C with five start pulses mid-run: they must change nothing.
        init_identity();
        launch(24'h00033C);
        fork
            begin
                for (int p = 0; p < 5; p++) begin
                    repeat (90) @(negedge clock);
                    start = 1'b1;
                    @(negedge clock);
                    start = 1'b0;
                end
            end
        join_none
        finish_run("k00033C");

        // Abort around iteration 10, then restart from the partially swapped memory.
        init_identity();
        launch(24'h00033C);
        for (int k = 0; k < 200 && exp_q.size() > m_total - 71; k++) @(negedge clock);
        trace_on = 1'b0;
        exp_q.delete();
        #2 reset_n = 1'b0;
        #1 check("abort outputs", {address, data, wren, busy, done}, 32'd0);
        repeat (2) @(negedge clock);
        check("abort idle", {address, data, wren, busy, done}, 32'd0);
        reset_n = 1'b1;
        launch(24'h00033C);
        check("restart first read", 32'(exp_q[0].a), 32'd0);
        finish_run("restart");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
